alarm_zone_ctrl: RTL and testbench
==================================

// Module: alarm_zone_ctrl
// PURPOSE
//  Multi-zone alarm controller; parametrised successor to the single-button alarm FSM.
//  Debounces N zone sensors plus arm/disarm buttons, runs exit and entry delays, and latches which zones tripped.
//  Drives the alarm output and status to the top-level pins. All logic is in one clock domain.
// PARAMETERS
//  N_ZONES      4    number of sensor zones (1..8)
//  DEB_CYCLES   4    consecutive identical samples needed to accept a new input level (>=1)
//  EXIT_DLY     31   cycles in ARMING before ARMED (>=1)
//  ENTRY_DLY    15   cycles in ENTRY before ALERT (>=1)
//  INSTANT_MASK 4'b0001  zones whose trip bypasses ENTRY and goes straight to ALERT
//  CNT_W        8    timer width; must hold max(EXIT_DLY, ENTRY_DLY, ALERT_TMO)
//  ALERT_TMO    63   ALERT duration before auto re-arm (used only with ALARM_AUTO_REARM_EN)
// PORTS
//  clk          in   1        system clock
//  reset        in   1        synchronous, active-high reset
//  zone_n       in   N_ZONES  raw zone sensors, active-low (0 = tripped), asynchronous
//  zone_en      in   N_ZONES  per-zone enable; disabled zones are ignored
//  arm_n        in   1        raw arm button, active-low, asynchronous
//  disarm_n     in   1        raw disarm button, active-low, asynchronous
//  alarm        out  1        1 while in ALERT
//  state        out  3        encoded FSM state
//  timer        out  CNT_W    remaining delay count; 0 outside the timed states
//  tripped      out  N_ZONES  latched set of zones that caused or joined the alarm
// BEHAVIOUR
//  Input path, per raw input:
//   - 2-flop synchroniser, then debounce.
//   - Debounced level changes on the edge where DEB_CYCLES consecutive synced samples all differ from the current level.
//   - Latency from raw change to debounced change is 2+DEB_CYCLES cycles.
//   - Shorter glitches are discarded and the count restarts.
//   - Press pulse (1 cycle) fires on a debounced 1->0 transition. Zone trip is the debounced level 0 AND zone_en.
//  Reset values:
//   - All debounced levels 1; state IDLE; alarm 0; timer 0; tripped 0.
//  FSM (encodings in the package):
//   - IDLE:     arm press -> ARMING, timer <= EXIT_DLY.
//   - ARMING:   timer decrements each cycle; zone trips ignored; at timer==1 -> ARMED next edge, timer <= 0.
//   - ARMED:    any trip in INSTANT_MASK -> ALERT. Otherwise any trip -> ENTRY, timer <= ENTRY_DLY.
//   - ENTRY:    decrement; an instant-zone trip -> ALERT immediately; at timer==1 -> ALERT.
//   - ALERT:    alarm=1; stays until disarm (see optional feature).
//  Disarm press in any state other than IDLE -> IDLE next edge; clears timer and tripped.
//  Arm press outside IDLE is ignored.
//  Same-cycle arm and disarm presses: disarm wins.
//  tripped:
//   - Bits are set (OR) for each active trip in ARMED, ENTRY and ALERT.
//   - Bits are never set in IDLE or ARMING.
//   - Bits hold until disarm or reset.
//  Trip and disarm in the same cycle: disarm wins; tripped is cleared.
//  reset mid-operation returns every register to its reset value on that edge; the debouncers re-settle to released.
//  Timer never wraps: decrement is gated to nonzero values.
// CONFIGURATION
//  ALARM_AUTO_REARM_EN defined:
//   - On entry to ALERT, timer <= ALERT_TMO.
//   - At timer==1 -> ARMED; alarm drops; tripped is held.
//   - Disarm during ALERT still goes to IDLE.
//  ALARM_AUTO_REARM_EN undefined: ALERT holds indefinitely; timer reads 0 in ALERT; ALERT_TMO is unused.
// STRUCTURE
//  Package alarm_pkg: state encodings IDLE=0, ARMING=1, ARMED=2, ENTRY=3, ALERT=4; state width 3.
//  Sub-module alarm_debounce (sync + debounce + press pulse, parameter DEB_CYCLES):
//   - Instantiated N_ZONES+2 times, via a generate loop for the zones.
//  Top-level block holds the FSM, timer and tripped register.
// TESTING
//  1. Reset, arm_n low 10 cycles, DEB=4 -> state ARMING on cycle 6 after assertion.
//     timer=31 on that cycle; ARMED 31 cycles later.
//  2. ARMED, zone_n[2] low and held -> ENTRY at debounce; ALERT after 15 cycles; alarm=1; tripped=4'b0100.
//  3. ENTRY, then zone_n[0] trips -> ALERT on the edge after debounce; tripped=4'b0101.
//  4. 3-cycle glitch on zone_n[1] while ARMED -> no state change; tripped stays 0.
//  5. ARMING, same-cycle arm and disarm presses -> IDLE, timer 0.
//     Zone trips during ARMING leave tripped at 0.
//  6. ALARM_AUTO_REARM_EN: ALERT -> ARMED after 63 cycles with tripped held.
//     Without the macro, still ALERT after 200 cycles; reset mid-ALERT -> IDLE, alarm 0 next cycle.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared state encodings and helpers for the multi-zone alarm controller.
package alarm_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_ARMING = 3'd1,
      ST_ARMED  = 3'd2,
      ST_ENTRY  = 3'd3,
      ST_ALERT  = 3'd4
   } state_t;

   // Bits needed for a counter that runs 0..n-1, never narrower than one bit.
   function automatic int cnt_bits(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/alarm_debounce.sv
// Two-flop synchroniser plus level debouncer for one raw active-low input;
// press pulses in the cycle whose closing edge commits a debounced 1->0 change.
module alarm_debounce
   import alarm_pkg::*;
#(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CW = cnt_bits(DEB_CYCLES);

   logic          sync_q1;
   logic          sync_q2;
   logic [CW-1:0] run_cnt;
   logic          settle;

   // Current synced sample is the last of DEB_CYCLES consecutive ones that disagree with level.
   assign settle = (sync_q2 != level) && (run_cnt == CW'(DEB_CYCLES - 1));
   assign press  = settle && level;

   // NOTE: the synchroniser resets to the released level so no false press follows reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
         level   <= 1'b1;
         run_cnt <= '0;
      end else begin
         sync_q1 <= raw;
         sync_q2 <= sync_q1;
         if (sync_q2 == level) begin
            run_cnt <= '0;
         end else if (settle) begin
            level   <= sync_q2;
            run_cnt <= '0;
         end else begin
            run_cnt <= run_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/alarm_zone_ctrl.sv
// Multi-zone alarm controller: debounced zones and buttons, exit/entry delays, tripped latch.
// Define ALARM_AUTO_REARM_EN to make ALERT time out after ALERT_TMO cycles and re-arm.
module alarm_zone_ctrl
   import alarm_pkg::*;
#(
   parameter int                 N_ZONES      = 4,
   parameter int                 DEB_CYCLES   = 4,
   parameter int                 EXIT_DLY     = 31,
   parameter int                 ENTRY_DLY    = 15,
   parameter logic [N_ZONES-1:0] INSTANT_MASK = N_ZONES'(1),
   parameter int                 CNT_W        = 8,
   parameter int                 ALERT_TMO    = 63
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_ZONES-1:0] zone_n,
   input  logic [N_ZONES-1:0] zone_en,
   input  logic               arm_n,
   input  logic               disarm_n,
   output logic               alarm,
   output logic [STATE_W-1:0] state,
   output logic [CNT_W-1:0]   timer,
   output logic [N_ZONES-1:0] tripped
);

   if (max3(EXIT_DLY, ENTRY_DLY, ALERT_TMO) >= (1 << CNT_W)) begin : g_cnt_w_check
      $error("alarm_zone_ctrl: CNT_W too narrow for the configured delays");
   end

`ifdef ALARM_AUTO_REARM_EN
   localparam logic [CNT_W-1:0] ALERT_LOAD = CNT_W'(ALERT_TMO);
`else
   localparam logic [CNT_W-1:0] ALERT_LOAD = '0;
`endif

   logic [N_ZONES-1:0] zone_lvl;
   logic [N_ZONES-1:0] zone_fall;
   logic               arm_lvl;
   logic               arm_press;
   logic               disarm_lvl;
   logic               disarm_press;

   for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
      alarm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk   (clk),
         .reset (reset),
         .raw   (zone_n[i]),
         .level (zone_lvl[i]),
         .press (zone_fall[i])
      );
   end

   alarm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_arm_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (arm_n),
      .level (arm_lvl),
      .press (arm_press)
   );

   alarm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_disarm_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (disarm_n),
      .level (disarm_lvl),
      .press (disarm_press)
   );

   logic unused_ok;
   assign unused_ok = &{1'b0, zone_fall, arm_lvl, disarm_lvl};

   logic [N_ZONES-1:0] trip;
   logic               instant_trip;
   logic               any_trip;

   assign trip         = ~zone_lvl & zone_en;
   assign instant_trip = |(trip & INSTANT_MASK);
   assign any_trip     = |trip;

   state_t st;
   assign state = st;

   always_ff @(posedge clk) begin
      if (reset) begin
         st      <= ST_IDLE;
         timer   <= '0;
         tripped <= '0;
         alarm   <= 1'b0;
      end else if (disarm_press && st != ST_IDLE) begin
         st      <= ST_IDLE;
         timer   <= '0;
         tripped <= '0;
         alarm   <= 1'b0;
      end else begin
         if (st inside {ST_ARMED, ST_ENTRY, ST_ALERT}) begin
            tripped <= tripped | trip;
         end
         case (st)
            ST_IDLE: begin
               // A simultaneous disarm press suppresses arming here too.
               if (arm_press && !disarm_press) begin
                  st    <= ST_ARMING;
                  timer <= CNT_W'(EXIT_DLY);
               end
            end
            ST_ARMING: begin
               if (timer == CNT_W'(1)) begin
                  st    <= ST_ARMED;
                  timer <= '0;
               end else if (timer != '0) begin
                  timer <= timer - CNT_W'(1);
               end
            end
            ST_ARMED: begin
               if (instant_trip) begin
                  st    <= ST_ALERT;
                  timer <= ALERT_LOAD;
                  alarm <= 1'b1;
               end else if (any_trip) begin
                  st    <= ST_ENTRY;
                  timer <= CNT_W'(ENTRY_DLY);
               end
            end
            ST_ENTRY: begin
               if (instant_trip || timer == CNT_W'(1)) begin
                  st    <= ST_ALERT;
                  timer <= ALERT_LOAD;
                  alarm <= 1'b1;
               end else if (timer != '0) begin
                  timer <= timer - CNT_W'(1);
               end
            end
            ST_ALERT: begin
`ifdef ALARM_AUTO_REARM_EN
               if (timer == CNT_W'(1)) begin
                  st    <= ST_ARMED;
                  timer <= '0;
                  alarm <= 1'b0;
               end else if (timer != '0) begin
                  timer <= timer - CNT_W'(1);
               end
`else
               alarm <= 1'b1;
`endif
            end
            default: begin
               st    <= ST_IDLE;
               timer <= '0;
               alarm <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Self-checking bench for alarm_zone_ctrl: directed vector table, corner sequences, random vs model.
module tb_alarm_zone_ctrl;
   import alarm_pkg::*;

   localparam int         NZ    = 4;
   localparam int         DEB   = 4;
   localparam int         EXIT  = 31;
   localparam int         ENTRY = 15;
   localparam int         TMO   = 63;
   localparam int         CW    = 8;
   localparam logic [3:0] INST  = 4'b0001;
`ifdef ALARM_AUTO_REARM_EN
   localparam int ALERT_T0 = TMO;
`else
   localparam int ALERT_T0 = 0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [NZ-1:0] zone_n;
   logic [NZ-1:0] zone_en;
   logic          arm_n;
   logic          disarm_n;
   logic          alarm;
   logic [2:0]    state;
   logic [CW-1:0] timer;
   logic [NZ-1:0] tripped;

   always #5 clk = ~clk;

   alarm_zone_ctrl #(
      .N_ZONES(NZ), .DEB_CYCLES(DEB), .EXIT_DLY(EXIT), .ENTRY_DLY(ENTRY),
      .INSTANT_MASK(INST), .CNT_W(CW), .ALERT_TMO(TMO)
   ) dut (
      .clk(clk), .reset(reset), .zone_n(zone_n), .zone_en(zone_en),
      .arm_n(arm_n), .disarm_n(disarm_n), .alarm(alarm), .state(state),
      .timer(timer), .tripped(tripped)
   );

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [15:0] pack(input int st, input logic al, input logic [3:0] tr, input int tm);
      return {3'(st), al, tr, 8'(tm)};
   endfunction

   function automatic logic [15:0] dut_vec();
      return {state, alarm, tripped, timer};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got state=%0d alarm=%0b tripped=%b timer=%0d, expected state=%0d alarm=%0b tripped=%b timer=%0d",
                  name, act[15:13], act[12], act[11:8], act[7:0], exp[15:13], exp[12], exp[11:8], exp[7:0]);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic a, input logic d, input logic [3:0] zn, input logic [3:0] ze);
      arm_n    = a;
      disarm_n = d;
      zone_n   = zn;
      zone_en  = ze;
   endtask

   // Reference model: raw samples are logged per edge; a debounced level flips when
   // the last DEB synchronised samples (raw delayed two edges) all disagree with it.
   bit         raw_log[6][64];
   bit         m_lvl[6];
   int         ec;
   int         m_state;
   int         m_timer;
   logic [3:0] m_trip;

   function automatic bit synced(input int i, input int k);
      return (k <= 2) ? 1'b1 : raw_log[i][(k - 2) % 64];
   endfunction

   task automatic model_edge();
      bit         old_lvl[6];
      bit         fall[6];
      bit         win;
      logic [3:0] trip;
      if (reset) begin
         ec = 0;
         for (int i = 0; i < 6; i++) m_lvl[i] = 1'b1;
         m_state = ST_IDLE;
         m_timer = 0;
         m_trip  = '0;
         return;
      end
      ec++;
      for (int i = 0; i < NZ; i++) raw_log[i][ec % 64] = zone_n[i];
      raw_log[4][ec % 64] = arm_n;
      raw_log[5][ec % 64] = disarm_n;
      for (int i = 0; i < 6; i++) begin
         old_lvl[i] = m_lvl[i];
         if (ec >= DEB) begin
            win = 1'b1;
            for (int j = ec - DEB + 1; j <= ec; j++)
               if (synced(i, j) == m_lvl[i]) win = 1'b0;
            if (win) m_lvl[i] = !m_lvl[i];
         end
         fall[i] = old_lvl[i] && !m_lvl[i];
      end
      for (int i = 0; i < NZ; i++) trip[i] = !old_lvl[i] && zone_en[i];

      if (fall[5] && m_state != ST_IDLE) begin
         m_state = ST_IDLE;
         m_timer = 0;
         m_trip  = '0;
      end else begin
         if (m_state >= ST_ARMED) m_trip = m_trip | trip;
         case (m_state)
            ST_IDLE:
               if (fall[4] && !fall[5]) begin m_state = ST_ARMING; m_timer = EXIT; end
            ST_ARMING:
               if (m_timer <= 1) begin m_state = ST_ARMED; m_timer = 0; end
               else m_timer--;
            ST_ARMED:
               if ((trip & INST) != 0) begin m_state = ST_ALERT; m_timer = ALERT_T0; end
               else if (trip != 0) begin m_state = ST_ENTRY; m_timer = ENTRY; end
            ST_ENTRY:
               if ((trip & INST) != 0 || m_timer == 1) begin m_state = ST_ALERT; m_timer = ALERT_T0; end
               else if (m_timer > 0) m_timer--;
            default: begin
`ifdef ALARM_AUTO_REARM_EN
               if (m_timer == 1) begin m_state = ST_ARMED; m_timer = 0; end
               else if (m_timer > 0) m_timer--;
`endif
            end
         endcase
      end
   endtask

   always @(posedge clk) model_edge();

   typedef struct {
      string      name;
      logic       arm_n;
      logic       disarm_n;
      logic [3:0] zone_n;
      logic [3:0] zone_en;
      int         cycles;
      int         st;
      int         tm;
      logic       al;
      logic [3:0] tr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string nm, input logic a, input logic d, input logic [3:0] zn,
                      input logic [3:0] ze, input int cyc, input int st, input int tm,
                      input logic al, input logic [3:0] tr);
      vec_t v;
      v = '{nm, a, d, zn, ze, cyc, st, tm, al, tr};
      vecs.push_back(v);
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b1, 1'b1, 4'b1111, 4'b1111);
      step(2);
      check("reset", dut_vec(), pack(ST_IDLE, 1'b0, 4'b0000, 0));
      reset = 1'b0;

      //   name             arm  dis  zone_n   zone_en  cyc  state      timer     al    tripped
      add("idle_quiet",     1,   1,   4'b1111, 4'b1111, 3,   ST_IDLE,   0,        1'b0, 4'b0000);
      add("arm_pre",        0,   1,   4'b1111, 4'b1111, 5,   ST_IDLE,   0,        1'b0, 4'b0000);
      add("arm_edge6",      0,   1,   4'b1111, 4'b1111, 1,   ST_ARMING, EXIT,     1'b0, 4'b0000);
      add("arming_dec",     1,   1,   4'b1111, 4'b1111, 1,   ST_ARMING, EXIT-1,   1'b0, 4'b0000);
      add("arming_last",    1,   1,   4'b1111, 4'b1111, 29,  ST_ARMING, 1,        1'b0, 4'b0000);
      add("armed",          1,   1,   4'b1111, 4'b1111, 1,   ST_ARMED,  0,        1'b0, 4'b0000);
      add("z2_debouncing",  1,   1,   4'b1011, 4'b1111, 6,   ST_ARMED,  0,        1'b0, 4'b0000);
      add("entry",          1,   1,   4'b1011, 4'b1111, 1,   ST_ENTRY,  ENTRY,    1'b0, 4'b0100);
      add("entry_last",     1,   1,   4'b1011, 4'b1111, 14,  ST_ENTRY,  1,        1'b0, 4'b0100);
      add("alert",          1,   1,   4'b1011, 4'b1111, 1,   ST_ALERT,  ALERT_T0, 1'b1, 4'b0100);
      add("disarm_alert",   1,   0,   4'b1111, 4'b1111, 6,   ST_IDLE,   0,        1'b0, 4'b0000);
      add("disarm_rel",     1,   1,   4'b1111, 4'b1111, 6,   ST_IDLE,   0,        1'b0, 4'b0000);
      add("rearm",          0,   1,   4'b1111, 4'b1111, 6,   ST_ARMING, EXIT,     1'b0, 4'b0000);
      add("rearmed",        1,   1,   4'b1111, 4'b1111, 31,  ST_ARMED,  0,        1'b0, 4'b0000);
      add("glitch_z1",      1,   1,   4'b1101, 4'b1111, 3,   ST_ARMED,  0,        1'b0, 4'b0000);
      add("glitch_after",   1,   1,   4'b1111, 4'b1111, 10,  ST_ARMED,  0,        1'b0, 4'b0000);
      add("z2_disabled",    1,   1,   4'b1011, 4'b1011, 10,  ST_ARMED,  0,        1'b0, 4'b0000);
      add("z2_enabled",     1,   1,   4'b1011, 4'b1111, 1,   ST_ENTRY,  ENTRY,    1'b0, 4'b0100);
      add("z0_glide",       1,   1,   4'b1010, 4'b1111, 3,   ST_ENTRY,  ENTRY-3,  1'b0, 4'b0100);
      add("z0_debounced",   1,   1,   4'b1010, 4'b1111, 3,   ST_ENTRY,  ENTRY-6,  1'b0, 4'b0100);
      add("z0_instant",     1,   1,   4'b1010, 4'b1111, 1,   ST_ALERT,  ALERT_T0, 1'b1, 4'b0101);
      add("disarm2",        1,   0,   4'b1111, 4'b1111, 6,   ST_IDLE,   0,        1'b0, 4'b0000);
      add("disarm2_rel",    1,   1,   4'b1111, 4'b1111, 6,   ST_IDLE,   0,        1'b0, 4'b0000);
      add("arm3",           0,   1,   4'b1111, 4'b1111, 6,   ST_ARMING, EXIT,     1'b0, 4'b0000);
      add("arming_trips",   1,   1,   4'b0000, 4'b1111, 12,  ST_ARMING, EXIT-12,  1'b0, 4'b0000);
      add("both_pre",       0,   0,   4'b1111, 4'b1111, 5,   ST_ARMING, EXIT-17,  1'b0, 4'b0000);
      add("both_disarm",    0,   0,   4'b1111, 4'b1111, 1,   ST_IDLE,   0,        1'b0, 4'b0000);
      add("both_rel",       1,   1,   4'b1111, 4'b1111, 6,   ST_IDLE,   0,        1'b0, 4'b0000);
      add("idle_both",      0,   0,   4'b1111, 4'b1111, 6,   ST_IDLE,   0,        1'b0, 4'b0000);
      add("idle_both_rel",  1,   1,   4'b1111, 4'b1111, 6,   ST_IDLE,   0,        1'b0, 4'b0000);

      foreach (vecs[i]) begin
         drive(vecs[i].arm_n, vecs[i].disarm_n, vecs[i].zone_n, vecs[i].zone_en);
         step(vecs[i].cycles);
         check(vecs[i].name, dut_vec(), pack(vecs[i].st, vecs[i].al, vecs[i].tr, vecs[i].tm));
      end

      // ALERT hold / auto re-arm, then reset in the middle of ALERT.
      drive(1'b0, 1'b1, 4'b1111, 4'b1111);
      step(6);
      drive(1'b1, 1'b1, 4'b1111, 4'b1111);
      step(31);
      check("seq_armed", dut_vec(), pack(ST_ARMED, 1'b0, 4'b0000, 0));
      drive(1'b1, 1'b1, 4'b1110, 4'b1111);
      step(7);
      check("seq_alert", dut_vec(), pack(ST_ALERT, 1'b1, 4'b0001, ALERT_T0));
      drive(1'b1, 1'b1, 4'b1111, 4'b1111);
`ifdef ALARM_AUTO_REARM_EN
      step(TMO - 1);
      check("seq_tmo_last", dut_vec(), pack(ST_ALERT, 1'b1, 4'b0001, 1));
      step(1);
      check("seq_rearmed", dut_vec(), pack(ST_ARMED, 1'b0, 4'b0001, 0));
      drive(1'b1, 1'b1, 4'b1110, 4'b1111);
      step(7);
      check("seq_alert2", dut_vec(), pack(ST_ALERT, 1'b1, 4'b0001, ALERT_T0));
`else
      step(200);
      check("seq_alert_hold", dut_vec(), pack(ST_ALERT, 1'b1, 4'b0001, 0));
`endif
      reset = 1'b1;
      drive(1'b1, 1'b1, 4'b1111, 4'b1111);
      step(1);
      check("seq_reset", dut_vec(), pack(ST_IDLE, 1'b0, 4'b0000, 0));
      reset = 1'b0;
      step(6);
      check("seq_post_reset", dut_vec(), pack(ST_IDLE, 1'b0, 4'b0000, 0));

      // Randomised segments compared against the reference model every cycle.
      for (int seg = 0; seg < 400; seg++) begin
         int len;
         logic [3:0] zn;
         for (int z = 0; z < NZ; z++) zn[z] = ($urandom_range(0, 2) != 0);
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0), zn, 4'($urandom));
         reset = ($urandom_range(0, 99) == 0);
         len = $urandom_range(1, 14);
         repeat (len) begin
            step(1);
            check("rand", dut_vec(), pack(m_state, m_state == ST_ALERT, m_trip, m_timer));
         end
         reset = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
